// File: rtl/fetch_pkg.sv
// +--------------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch unit    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  localparam int          DEFAULT_DEPTH = 2;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +--------------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry {pc, inst} queue with push, pop and flush       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [31:0]                push_pc_i,
  input  logic [31:0]                push_inst_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [31:0]                head_pc_o,
  output logic [31:0]                head_inst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      pc_mem_q[wr_ptr_q]   <= push_pc_i;
      inst_mem_q[wr_ptr_q] <= push_inst_i;
    end
  end

  assign head_pc_o   = pc_mem_q[rd_ptr_q];
  assign head_inst_o = inst_mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------------+
// | fetch_unit : sequential instruction fetch with redirect and queue        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [31:0]   head_pc, head_inst;

  assign pop  = inst_valid_o & inst_ready_i & ~redirect_i;
  assign push = (state_q == ST_WAIT) & imem_ack_i & ~redirect_i;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!redirect_i && !full) begin
          state_d = ST_WAIT;
          addr_d  = fpc_q;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          state_d = imem_ack_i ? ST_IDLE : ST_SQUASH;
        end else if (imem_ack_i) begin
          addr_d = addr_q + 32'd4;
          fpc_d  = addr_q + 32'd4;
          // Without a pop this push fills the last free slot.
          if (!pop && (count == CW'(DEPTH - 1))) state_d = ST_IDLE;
        end
      end
      ST_SQUASH: begin
        if (imem_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect_i) fpc_d = align_pc(redirect_pc_i);
    req_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_pc_i   (addr_q),
    .push_inst_i (imem_data_i),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = ~empty;
  assign inst_o       = empty ? 32'h0 : head_inst;
  assign inst_pc_o    = empty ? 32'h0 : head_pc;

endmodule

`default_nettype wire
